tdc_pulse_gen: RTL and testbench
================================

Name: tdc_pulse_gen

Overview:
- Programmable two-channel pulse-pair transmitter that drives known-delay edges into the timetagger signal inputs. It is the generating end of the TDC measurement path: the timetagger receives edges, and this block emits them.
- Used for self-test and for delay-line calibration cross-checks.
- Sits in sys_clk domain in the system top; pulse_o feeds the tdc_signal mux/output buffers.

Parameters:
- CNT_W, 24, width of period/width/delay counters (cycles of clk_i)
- NUM_W, 16, width of pulse-pair count field

Ports:
- clk_i  input  1  system clock (sys_clk)
- reset_i  input  1  synchronous, active-low reset
- cfg_valid_i  input  1  config offer
- cfg_ready_o  output  1  config accepted when valid&ready
- cfg_period_i  input  CNT_W  repetition period, cycles
- cfg_width_i  input  CNT_W  high time of each pulse, cycles
- cfg_delay_i  input  CNT_W  ch1 rising edge offset after ch0 rising edge, cycles
- cfg_count_i  input  NUM_W  pulse pairs to emit; 0 = continuous
- cfg_err_o  output  1  last offered config rejected (sticky)
- start_i  input  1  begin run (level sampled)
- stop_i  input  1  request graceful stop
- pulse_o  output  2  [0] reference pulse, [1] delayed pulse
- busy_o  output  1  run in progress
- done_o  output  1  one-cycle strobe at run end
- pair_cnt_o  output  NUM_W  pairs completed in current/last run

Behaviour:
- Reset (reset_i low at edge): state IDLE; pulse_o=0, busy_o=0, done_o=0, cfg_err_o=0, pair_cnt_o=0, cfg_ok=0 (no valid config held). Mid-run reset forces all of these at that edge, with no drain.
- States:
  - IDLE: cfg_ready_o=1.
  - RUN: cfg_ready_o=0; offers are ignored.
- Config check on accept, performed in CNT_W+1 bits:
  - Valid iff period>=2, width>=1, and delay+width<=period.
  - Valid: latch fields, cfg_ok=1, cfg_err_o=0.
  - Invalid: keep the previous config and cfg_ok, set cfg_err_o=1.
- IDLE->RUN when start_i=1 & cfg_ok & !stop_i at an edge.
  - At that edge: phase cnt=0, pair_cnt_o=0, busy_o=1, pulse_o[0]=1; pulse_o[1]=1 iff delay==0.
  - Start with !cfg_ok: ignored.
  - start_i&stop_i together in IDLE: stay IDLE.
- RUN phase counter cnt runs 0..period-1 and wraps to 0. Outputs are registered from the next-cnt value, so:
  - pulse_o[0]=1 for cnt in [0, width-1].
  - pulse_o[1]=1 for cnt in [delay, delay+width-1].
  - Latency: ch1 rising edge trails ch0 rising edge by exactly delay cycles. Both pulses are exactly width cycles high.
- Pair completion: on wrap (cnt==period-1), pair_cnt_o increments (wraps mod 2^NUM_W in continuous mode).
- Run end at wrap when either:
  - count!=0 and pair_cnt_o+1==count, or
  - stop_pending=1.
  - At that edge: state IDLE, busy_o=0, pulse_o=0, done_o=1 for one cycle.
- stop_i in RUN sets stop_pending; the current period always completes. stop_pending clears on entry to IDLE.
- No partial pulses are ever emitted except on reset.
- Back-to-back runs: start_i held high through done re-enters RUN on the cycle after done_o. There is at least one idle cycle with pulse_o=0 between runs.

Decomposition:
- Shared package tdc_pkg:
  - state enum {IDLE, RUN}
  - packed struct pulse_cfg_t {period, width, delay, count}
  - CNT_W/NUM_W defaults
- One sub-module: tdc_pulse_chan. It takes next-cnt, offset and width, and registers one pulse_o bit with its window compare. Instantiated twice: ch0 with offset 0, ch1 with offset delay.

Test Plan:
- Reset then cfg period=10, width=3, delay=4, count=2, start -> pulse_o[0] high cycles 0-2 and 10-12; pulse_o[1] high cycles 4-6 and 14-16; done_o at cycle 19; pair_cnt_o=2; busy_o low after.
- delay=0, width=5, period=5, count=1 -> both bits high together for cycles 0-4; done_o at cycle 4; no idle gap inside the run.
- Invalid cfg period=8, width=5, delay=4 -> cfg_err_o=1, cfg_ok retained. With no prior valid cfg, start ignored and busy_o stays 0.
- count=0 (continuous), period=6, stop_i pulsed at cnt=2 of pair 3 -> pulses finish pair 3; done_o at its cnt=5; pair_cnt_o=4.
- Reset asserted at cnt=1 of a run with width=3 -> pulse_o=0 at that edge, busy_o=0, no done_o. Subsequent start without reconfig is ignored (cfg_ok cleared).
- cfg_valid_i offered during RUN -> cfg_ready_o=0, the offer is not accepted, and the running pulse timing is unchanged.

Source files
------------

// File: rtl/tdc_pkg.sv
// tdc_pkg: shared state, config record and width defaults for the pulse-pair transmitter.
package tdc_pkg;
    localparam int CNT_W_DEF = 24;
    localparam int NUM_W_DEF = 16;

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] period;
        logic [CNT_W_DEF-1:0] width;
        logic [CNT_W_DEF-1:0] delay;
        logic [NUM_W_DEF-1:0] count;
    } pulse_cfg_t;
endpackage

// File: rtl/tdc_pulse_chan.sv
// tdc_pulse_chan: registers one pulse bit high while the next phase count is inside [offset, offset+width).
module tdc_pulse_chan #(
    parameter int CNT_W = 24
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] offset,
    input  logic [CNT_W-1:0] width,
    output logic             pulse
);
    logic [CNT_W:0] rel;

    assign rel = {1'b0, cnt} - {1'b0, offset};

    always_ff @(posedge clk_i) begin
        if (!reset_i) pulse <= 1'b0;
        else          pulse <= en && cnt >= offset && rel < {1'b0, width};
    end
endmodule

// File: rtl/tdc_pulse_gen.sv
// tdc_pulse_gen: programmable two-channel pulse-pair transmitter; ch1 trails ch0 by a fixed delay.
module tdc_pulse_gen
    import tdc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int NUM_W = NUM_W_DEF
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [CNT_W-1:0] cfg_period_i,
    input  logic [CNT_W-1:0] cfg_width_i,
    input  logic [CNT_W-1:0] cfg_delay_i,
    input  logic [NUM_W-1:0] cfg_count_i,
    output logic             cfg_err_o,
    input  logic             start_i,
    input  logic             stop_i,
    output logic [1:0]       pulse_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [NUM_W-1:0] pair_cnt_o
);
    state_t           state;
    pulse_cfg_t       cfg;
    logic             cfg_ok, stop_pending;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic [CNT_W:0]   end_edge;
    logic             cfg_good, go, wrap, fin, run_nxt;

    assign end_edge    = {1'b0, cfg_delay_i} + {1'b0, cfg_width_i};
    assign cfg_good    = cfg_period_i > CNT_W'(1) && cfg_width_i != '0 && end_edge <= {1'b0, cfg_period_i};
    assign cfg_ready_o = state == IDLE;
    assign go          = state == IDLE && start_i && cfg_ok && !stop_i;
    assign wrap        = state == RUN && cnt == cfg.period - 1'b1;
    assign fin         = wrap && ((cfg.count != '0 && pair_cnt_o + 1'b1 == cfg.count) || stop_pending);
    assign run_nxt     = go || (state == RUN && !fin);
    // Pulse bits are registered from the count the phase counter is about to take.
    assign nxt_cnt     = (go || wrap) ? '0 : cnt + 1'b1;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state        <= IDLE;
            cfg          <= '0;
            cfg_ok       <= 1'b0;
            cfg_err_o    <= 1'b0;
            stop_pending <= 1'b0;
            cnt          <= '0;
            pair_cnt_o   <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            done_o       <= fin;
            busy_o       <= run_nxt;
            cnt          <= nxt_cnt;
            stop_pending <= state == RUN && !fin && (stop_pending || stop_i);
            if (cfg_valid_i && cfg_ready_o) begin
                if (cfg_good) begin
                    cfg       <= '{period: cfg_period_i, width: cfg_width_i, delay: cfg_delay_i, count: cfg_count_i};
                    cfg_ok    <= 1'b1;
                    cfg_err_o <= 1'b0;
                end else begin
                    cfg_err_o <= 1'b1;
                end
            end
            if (go) begin
                state      <= RUN;
                pair_cnt_o <= '0;
            end else if (wrap) begin
                pair_cnt_o <= pair_cnt_o + 1'b1;
            end
            if (fin) state <= IDLE;
        end
    end

    tdc_pulse_chan #(.CNT_W(CNT_W)) u_ch0 (
        .clk_i(clk_i), .reset_i(reset_i), .en(run_nxt), .cnt(nxt_cnt),
        .offset('0), .width(cfg.width), .pulse(pulse_o[0])
    );

    tdc_pulse_chan #(.CNT_W(CNT_W)) u_ch1 (
        .clk_i(clk_i), .reset_i(reset_i), .en(run_nxt), .cnt(nxt_cnt),
        .offset(cfg.delay), .width(cfg.width), .pulse(pulse_o[1])
    );
endmodule

// File: tb/tb_tdc_pulse_gen.sv
// tb_tdc_pulse_gen: directed checks of pulse timing, config acceptance, stop and reset behaviour.
module tb_tdc_pulse_gen;
    logic        clk = 1'b0;
    logic        reset_i, cfg_valid_i, start_i, stop_i;
    logic [23:0] cfg_period_i, cfg_width_i, cfg_delay_i;
    logic [15:0] cfg_count_i;
    logic        cfg_ready_o, cfg_err_o, busy_o, done_o;
    logic [1:0]  pulse_o;
    logic [15:0] pair_cnt_o;
    int          n_asrt = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    tdc_pulse_gen dut (
        .clk_i(clk), .reset_i(reset_i), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .cfg_period_i(cfg_period_i), .cfg_width_i(cfg_width_i), .cfg_delay_i(cfg_delay_i),
        .cfg_count_i(cfg_count_i), .cfg_err_o(cfg_err_o), .start_i(start_i), .stop_i(stop_i),
        .pulse_o(pulse_o), .busy_o(busy_o), .done_o(done_o), .pair_cnt_o(pair_cnt_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input int p, input int w, input int d, input int c);
        cfg_period_i = 24'(p);
        cfg_width_i  = 24'(w);
        cfg_delay_i  = 24'(d);
        cfg_count_i  = 16'(c);
        cfg_valid_i  = 1'b1;
        tick();
        cfg_valid_i  = 1'b0;
    endtask

    initial begin
        reset_i = 1'b0; cfg_valid_i = 1'b0; start_i = 1'b0; stop_i = 1'b0;
        cfg_period_i = '0; cfg_width_i = '0; cfg_delay_i = '0; cfg_count_i = '0;
        tick(); tick();
        chk("rst_pulse", 64'(pulse_o), 0);
        chk("rst_busy", 64'(busy_o), 0);
        chk("rst_done", 64'(done_o), 0);
        chk("rst_err", 64'(cfg_err_o), 0);
        chk("rst_pair", 64'(pair_cnt_o), 0);
        chk("rst_ready", 64'(cfg_ready_o), 1);
        reset_i = 1'b1;

        // invalid config with nothing valid held: start must be ignored
        offer(8, 5, 4, 1);
        chk("inv_err", 64'(cfg_err_o), 1);
        start_i = 1'b1;
        tick(); tick();
        chk("inv_busy", 64'(busy_o), 0);
        chk("inv_pulse", 64'(pulse_o), 0);
        start_i = 1'b0;

        // period 10, width 3, delay 4, two pairs
        offer(10, 3, 4, 2);
        chk("t1_err", 64'(cfg_err_o), 0);
        start_i = 1'b1;
        for (int e = 0; e <= 21; e++) begin
            tick();
            start_i = 1'b0;
            chk("t1_p0", 64'(pulse_o[0]), 64'(e < 20 && e % 10 < 3));
            chk("t1_p1", 64'(pulse_o[1]), 64'(e < 20 && e % 10 >= 4 && e % 10 <= 6));
            chk("t1_done", 64'(done_o), 64'(e == 20));
            chk("t1_busy", 64'(busy_o), 64'(e < 20));
        end
        chk("t1_pair", 64'(pair_cnt_o), 2);

        // rejected offer keeps the old config; a run offer is ignored and timing is unchanged
        offer(8, 5, 4, 1);
        chk("t3_err", 64'(cfg_err_o), 1);
        start_i = 1'b1;
        for (int e = 0; e <= 21; e++) begin
            tick();
            start_i = 1'b0;
            cfg_period_i = 24'd6; cfg_width_i = 24'd1; cfg_delay_i = 24'd0; cfg_count_i = 16'd0;
            cfg_valid_i = e < 19;
            if (e < 20) chk("t6_ready", 64'(cfg_ready_o), 0);
            chk("t6_pulse", 64'(pulse_o), 64'({e < 20 && e % 10 >= 4 && e % 10 <= 6, e < 20 && e % 10 < 3}));
            chk("t6_done", 64'(done_o), 64'(e == 20));
        end
        cfg_valid_i = 1'b0;
        chk("t6_err", 64'(cfg_err_o), 1);
        chk("t6_pair", 64'(pair_cnt_o), 2);

        // delay 0, width == period: one solid 5-cycle pulse on both bits
        offer(5, 5, 0, 1);
        chk("t2_err", 64'(cfg_err_o), 0);
        start_i = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            tick();
            start_i = 1'b0;
            chk("t2_pulse", 64'(pulse_o), e < 5 ? 3 : 0);
            chk("t2_done", 64'(done_o), 64'(e == 5));
        end
        chk("t2_pair", 64'(pair_cnt_o), 1);

        // continuous mode, stop raised during cnt 2 of pair 3
        offer(6, 2, 3, 0);
        start_i = 1'b1;
        for (int e = 0; e <= 25; e++) begin
            tick();
            start_i = 1'b0;
            stop_i  = e == 20;
            if (e == 12) chk("t4_pair_mid", 64'(pair_cnt_o), 2);
            chk("t4_p0", 64'(pulse_o[0]), 64'(e < 24 && e % 6 < 2));
            chk("t4_p1", 64'(pulse_o[1]), 64'(e < 24 && e % 6 >= 3 && e % 6 <= 4));
            chk("t4_done", 64'(done_o), 64'(e == 24));
        end
        chk("t4_pair", 64'(pair_cnt_o), 4);

        // reset during cnt 1 of a run: everything clears, config is lost
        offer(10, 3, 4, 2);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        chk("t5_pre_pulse", 64'(pulse_o), 1);
        reset_i = 1'b0;
        tick();
        chk("t5_pulse", 64'(pulse_o), 0);
        chk("t5_busy", 64'(busy_o), 0);
        chk("t5_done", 64'(done_o), 0);
        reset_i = 1'b1;
        start_i = 1'b1;
        tick(); tick();
        chk("t5_restart_busy", 64'(busy_o), 0);
        chk("t5_restart_pulse", 64'(pulse_o), 0);
        start_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
